// File: rtl/u3_slave_fifo_master_if.sv
// USB3 slave-FIFO (GPIF) pin bundle between the FPGA master
// and the USB controller; all strobes are active low.
interface u3_slave_fifo_master_if #(
  parameter int U3_DATWD = 32
) ();
  logic                i_flaga;
  logic                i_flagb;
  logic [1:0]          ov_usb_addr;
  logic [U3_DATWD-1:0] ov_usb_data;
  logic                o_usb_wr;
  logic                o_usb_pkt;
  logic                o_usb_cs;
  logic                o_usb_oe;
  logic                o_usb_rd;

  modport master (
    input  i_flaga,
    input  i_flagb,
    output ov_usb_addr,
    output ov_usb_data,
    output o_usb_wr,
    output o_usb_pkt,
    output o_usb_cs,
    output o_usb_oe,
    output o_usb_rd
  );

  modport slave (
    output i_flaga,
    output i_flagb,
    input  ov_usb_addr,
    input  ov_usb_data,
    input  o_usb_wr,
    input  o_usb_pkt,
    input  o_usb_cs,
    input  o_usb_oe,
    input  o_usb_rd
  );
endinterface

// File: rtl/u3_slave_fifo_master.sv
// USB3 slave-FIFO write master: drains a show-ahead FIFO into
// the controller's two ping-pong socket buffers.
module u3_slave_fifo_master #(
  parameter int U3_DATWD     = 32,
  parameter int BUFFER_WORDS = 16'h1000,
  parameter int BUF_WD       = 16,
  parameter int SWITCH_WAIT  = 4,
  parameter int PKTEND_WAIT  = 24
) (
  input  logic                i_usb_pclk,
  input  logic                reset,
  input  logic                i_xfer_start,
  input  logic [31:0]         iv_xfer_size,
  output logic                o_xfer_busy,
  output logic                o_xfer_done,
  input  logic [U3_DATWD-1:0] iv_fifo_data,
  input  logic                i_fifo_empty,
  output logic                o_fifo_rd,
  u3_slave_fifo_master_if.master usb
);

  localparam int WAIT_MAX =
    (SWITCH_WAIT > PKTEND_WAIT) ? SWITCH_WAIT : PKTEND_WAIT;
  localparam int WAIT_WD = $clog2(WAIT_MAX + 2);

  localparam logic [BUF_WD-1:0] BUF_FULL =
    BUF_WD'(BUFFER_WORDS);
  localparam logic [WAIT_WD-1:0] SW_LD =
    WAIT_WD'(SWITCH_WAIT);
  localparam logic [WAIT_WD-1:0] PW_LD =
    WAIT_WD'(PKTEND_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FLAG,
    S_WRITE,
    S_PKTEND,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [31:0]         r_remain;
  logic [31:0]         w_remain_nx;
  logic [31:0]         w_remain_dec;
  logic [BUF_WD-1:0]   r_buf_cnt;
  logic [BUF_WD-1:0]   w_buf_cnt_nx;
  logic [BUF_WD-1:0]   w_buf_cnt_inc;
  logic [WAIT_WD-1:0]  r_wait;
  logic [WAIT_WD-1:0]  w_wait_nx;
  logic                r_final;
  logic                w_final_nx;
  logic                r_tog;
  logic                w_tog;
  logic                w_issue;
  logic                w_pkt;
  logic [1:0]          r_addr;
  logic [U3_DATWD-1:0] r_data;
  logic                r_wr;
  logic                r_pkt;
  logic                r_busy;
  logic                r_done;

  assign w_remain_dec  = r_remain - 32'd1;
  assign w_buf_cnt_inc = r_buf_cnt + BUF_WD'(1);

  always_ff @(posedge i_usb_pclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_remain_nx  = r_remain;
    w_buf_cnt_nx = r_buf_cnt;
    w_wait_nx    = r_wait;
    w_final_nx   = r_final;
    w_tog        = 1'b0;
    w_issue      = 1'b0;
    w_pkt        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_xfer_start) begin
          w_remain_nx  = iv_xfer_size;
          w_buf_cnt_nx = '0;
          w_final_nx   = 1'b0;
          if (iv_xfer_size == '0) begin
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_SETTLE;
            w_wait_nx  = SW_LD;
          end
        end
      end
      S_SETTLE: begin
        if (r_wait <= WAIT_WD'(1)) begin
          w_state_nx = r_final ? S_DONE : S_WAIT_FLAG;
        end else begin
          w_wait_nx = r_wait - WAIT_WD'(1);
        end
      end
      S_WAIT_FLAG: begin
        if (usb.i_flaga && usb.i_flagb) w_state_nx = S_WRITE;
      end
      S_WRITE: begin
        w_issue = !i_fifo_empty && usb.i_flaga &&
                  (r_remain != '0);
        if (w_issue) begin
          w_remain_nx = w_remain_dec;
          // full buffer commits itself; only a partial one needs pktend
          if (w_buf_cnt_inc == BUF_FULL) begin
            w_buf_cnt_nx = '0;
            w_tog        = 1'b1;
            if (w_remain_dec == '0) begin
              w_state_nx = S_DONE;
            end else begin
              w_state_nx = S_SETTLE;
              w_wait_nx  = SW_LD;
            end
          end else begin
            w_buf_cnt_nx = w_buf_cnt_inc;
            if (w_remain_dec == '0) w_state_nx = S_PKTEND;
          end
        end
      end
      S_PKTEND: begin
        w_pkt        = 1'b1;
        w_tog        = 1'b1;
        w_buf_cnt_nx = '0;
        w_final_nx   = 1'b1;
        w_wait_nx    = PW_LD;
        w_state_nx   = S_SETTLE;
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // address flips one cycle after the closing strobe reaches the pins
  always_ff @(posedge i_usb_pclk) begin
    if (reset) begin
      r_remain  <= '0;
      r_buf_cnt <= '0;
      r_wait    <= '0;
      r_final   <= 1'b0;
      r_tog     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wr      <= 1'b1;
      r_pkt     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_remain  <= w_remain_nx;
      r_buf_cnt <= w_buf_cnt_nx;
      r_wait    <= w_wait_nx;
      r_final   <= w_final_nx;
      r_tog     <= w_tog;
      if (r_tog) r_addr[0] <= ~r_addr[0];
      if (w_issue) r_data <= iv_fifo_data;
      r_wr      <= ~w_issue;
      r_pkt     <= ~w_pkt;
      r_busy    <= (w_state_nx != S_IDLE);
      r_done    <= (r_state == S_DONE);
    end
  end

  assign o_fifo_rd       = w_issue;
  assign o_xfer_busy     = r_busy;
  assign o_xfer_done     = r_done;
  assign usb.ov_usb_addr = r_addr;
  assign usb.ov_usb_data = r_data;
  assign usb.o_usb_wr    = r_wr;
  assign usb.o_usb_pkt   = r_pkt;
  assign usb.o_usb_cs    = ~r_busy;
  assign usb.o_usb_oe    = 1'b1;
  assign usb.o_usb_rd    = 1'b1;

endmodule
